alu_fpga_seq: RTL and testbench

Board-level sequenced test harness for the ALU, and the parametrised successor of the single-cycle switch/hex ALU wrapper. Pushbuttons are debounced into single-cycle press events. A small FSM steps through operand A entry, operand B entry, opcode entry, execute, and show. The registered result and flags drive a paged bank of seven-segment digits, so results wider than the display remain fully viewable. The ALU is external and connected through the alu_* ports.

---
 rtl/fpga_pkg.sv | 46 ++++
 rtl/key_debounce.sv | 55 +++++
 rtl/alu_fpga_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_fpga_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Shared types and helpers for the sequenced ALU board harness.
package fpga_pkg;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ENTER_OP,
    EXEC,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Width of the page register; at least one bit even with a single page.
  function automatic int unsigned page_width(input int unsigned data_w,
                                             input int unsigned ndigits);
    int unsigned npages;
    npages = (((data_w + 3) / 4) + ndigits - 1) / ndigits;
    return (npages > 1) ? $clog2(npages) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton debouncer: 2-FF synchroniser, stability counter, one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the stable level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  // Synchroniser and debounce state; idle level is released (1).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/alu_fpga_seq.sv
// Sequenced ALU test harness: debounced keys, operand/opcode entry FSM, paged hex display.
module alu_fpga_seq import fpga_pkg::*; #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SW_W         = 16,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned NDIGITS      = 8,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [3:0]                                 key_n,
  input  logic [SW_W-1:0]                            sw_data,
  input  logic                                       sw_ext,
  output logic [OP_W-1:0]                            alu_op,
  output logic [DATA_W-1:0]                          alu_a,
  output logic [DATA_W-1:0]                          alu_b,
  input  logic [DATA_W-1:0]                          alu_out,
  input  logic                                       alu_nf,
  input  logic                                       alu_vf,
  input  logic                                       alu_zf,
  output logic [7*NDIGITS-1:0]                       hex,
  output logic [2:0]                                 flags,
  output logic [2:0]                                 state_led,
  output logic [page_width(DATA_W, NDIGITS)-1:0]     page
);

  localparam int unsigned NNIB   = (DATA_W + 3) / 4;
  localparam int unsigned NPAGES = (NNIB + NDIGITS - 1) / NDIGITS;
  localparam int unsigned PAGE_W = page_width(DATA_W, NDIGITS);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NPAGES - 1);

  logic [3:0] key_level, key_press;
  logic       unused_keys;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
      .CLK  (CLK),
      .RST  (RST),
      .key_n(key_n[k]),
      .level(key_level[k]),
      .press(key_press[k])
    );
  end

  // Levels and the spare key are not needed by the sequencer.
  assign unused_keys = ^{key_level, key_press[3]};

  // Event priority: clear > commit > page.
  logic ev_clr, ev_cmt, ev_pg;
  assign ev_clr = key_press[1];
  assign ev_cmt = key_press[0] & ~ev_clr;
  assign ev_pg  = key_press[2] & ~ev_clr & ~key_press[0];

  logic [DATA_W-1:0] ext;
  assign ext = {{(DATA_W - SW_W){sw_ext}}, sw_data};

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [2:0]          flags_q, flags_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [7*NDIGITS-1:0] hex_q, hex_d;

  // Sequencer next state; EXEC always advances, only clear can preempt it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    page_d  = page_q;
    if (ev_clr) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      flags_d = '0;
      page_d  = '0;
    end else begin
      case (state_q)
        ENTER_A: if (ev_cmt) begin
          a_d     = ext;
          state_d = ENTER_B;
        end
        ENTER_B: if (ev_cmt) begin
          b_d     = ext;
          state_d = ENTER_OP;
        end
        ENTER_OP: if (ev_cmt) begin
          op_d    = sw_data[OP_W-1:0];
          state_d = EXEC;
        end
        EXEC: begin
          res_d   = alu_out;
          flags_d = {alu_nf, alu_vf, alu_zf};
          state_d = SHOW;
        end
        SHOW: if (ev_cmt) state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
      if (state_d != state_q) begin
        page_d = '0;
      end else if (ev_pg) begin
        page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0]  src;
  logic [4*NNIB-1:0]  src_pad;
  int unsigned        nib_idx;

  // Display source selection and per-digit nibble decode for the current page.
  always_comb begin
    case (state_q)
      ENTER_A, ENTER_B: src = ext;
      ENTER_OP:         src = DATA_W'(sw_data[OP_W-1:0]);
      default:          src = res_q;
    endcase
    src_pad = (4*NNIB)'(src);
    hex_d   = '0;
    nib_idx = 0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      nib_idx = int'(page_q) * NDIGITS + i;
      if (nib_idx >= NNIB || (state_q == ENTER_OP && i != 0)) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = hex2seg(src_pad[4*nib_idx +: 4]);
      end
    end
  end

  // All sequencer and display registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      page_q  <= '0;
      hex_q   <= {NDIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      page_q  <= page_d;
      hex_q   <= hex_d;
    end
  end

  // One-hot entry indicator, dark while executing or showing.
  always_comb begin
    state_led = 3'b000;
    case (state_q)
      ENTER_A:  state_led = 3'b001;
      ENTER_B:  state_led = 3'b010;
      ENTER_OP: state_led = 3'b100;
      default:  state_led = 3'b000;
    endcase
  end

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign hex    = hex_q;
  assign flags  = flags_q;
  assign page   = page_q;

endmodule

// File: tb/tb_alu_fpga_seq.sv
// Bench for alu_fpga_seq with an external add/concat ALU and a behavioural reference model.
module tb_alu_fpga_seq;

  localparam int DB = 4;
  localparam int PRESS_LAT = 2 + DB;  // sync stages + stability count
  localparam int S_A = 0, S_B = 1, S_OP = 2, S_SHOW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_n;
  logic [15:0] sw_data;
  logic        sw_ext;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_nf, alu_vf, alu_zf;
  logic [27:0] hex;
  logic [2:0]  flags, state_led;
  logic [0:0]  page;

  int checks = 0;
  int failures = 0;

  int          m_state;
  logic [31:0] m_res;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  alu_fpga_seq #(
    .DATA_W(32), .SW_W(16), .OP_W(4), .NDIGITS(4), .DEBOUNCE_CYC(DB)
  ) dut (
    .CLK(clk), .RST(rst), .key_n(key_n), .sw_data(sw_data), .sw_ext(sw_ext),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_nf(alu_nf), .alu_vf(alu_vf), .alu_zf(alu_zf),
    .hex(hex), .flags(flags), .state_led(state_led), .page(page)
  );

  always #5 clk = ~clk;

  // External ALU: op 1 packs low halves, anything else adds.
  always_comb begin
    alu_vf = 1'b0;
    if (alu_op == 4'd1) begin
      alu_out = {alu_a[15:0], alu_b[15:0]};
    end else begin
      alu_out = alu_a + alu_b;
      alu_vf  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
    end
    alu_nf = alu_out[31];
    alu_zf = (alu_out == 32'd0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] mask);
    key_n = ~mask;
    repeat (PRESS_LAT + 2) tick();
    key_n = 4'hF;
    repeat (PRESS_LAT + 2) tick();
  endtask

  function automatic logic [31:0] mk_ext(input logic [15:0] sw, input logic e);
    return e ? {16'hFFFF, sw} : {16'h0000, sw};
  endfunction

  // Reference ALU from arithmetic rules: {nf,vf,zf,result}.
  function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [31:0] r;
    logic        v;
    longint      s;
    if (op == 4'd1) begin
      r = (a << 16) | (b & 32'h0000FFFF);
      v = 1'b0;
    end else begin
      s = longint'(signed'(a)) + longint'(signed'(b));
      r = a + b;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[31], v, (r == 32'd0), r};
  endfunction

  function automatic logic [27:0] exp_hex(input int st, input logic [31:0] v, input int pg);
    logic [27:0] h;
    logic [3:0]  nib;
    int          n;
    h = '0;
    for (int d = 0; d < 4; d++) begin
      n = pg * 4 + d;
      if (n >= 8 || (st == S_OP && d != 0)) begin
        h[7*d +: 7] = 7'h7F;
      end else begin
        nib = 4'((v >> (4 * n)) & 32'hF);
        h[7*d +: 7] = seg_tab[nib];
      end
    end
    return h;
  endfunction

  // Enter A, B, opcode and execute, checking entry displays and result latency.
  task automatic run_op(input logic [15:0] asw, input logic aex, input logic [15:0] bsw,
                        input logic bex, input logic [3:0] op);
    logic [31:0] ea, eb;
    logic [34:0] r;
    if (m_state == S_SHOW) begin
      sw_data = asw; sw_ext = aex;
      push(4'b0001);
      m_state = S_A;
      chk("show_to_a_led", state_led, 3'b001);
      chk("show_to_a_page", page, 1'b0);
    end
    sw_data = asw; sw_ext = aex;
    tick(); tick();
    ea = mk_ext(asw, aex);
    chk("hex_live_a", hex, exp_hex(S_A, ea, 0));
    push(4'b0001);
    chk("alu_a", alu_a, ea);
    chk("led_b", state_led, 3'b010);
    sw_data = bsw; sw_ext = bex;
    tick(); tick();
    eb = mk_ext(bsw, bex);
    chk("hex_live_b", hex, exp_hex(S_B, eb, 0));
    push(4'b0001);
    chk("alu_b", alu_b, eb);
    chk("alu_a_held", alu_a, ea);
    chk("led_op", state_led, 3'b100);
    sw_data = {12'h000, op}; sw_ext = 1'b1;
    tick(); tick();
    chk("hex_op", hex, exp_hex(S_OP, {28'h0, op}, 0));
    r = ref_alu(ea, eb, op);
    key_n[0] = 1'b0;
    repeat (PRESS_LAT + 1) tick();
    chk("exec_led", state_led, 3'b000);
    chk("alu_op", alu_op, op);
    tick();
    chk("flags", flags, r[34:32]);
    chk("hex_before_result", hex, exp_hex(S_SHOW, m_res, 0));
    tick();
    chk("hex_result", hex, exp_hex(S_SHOW, r[31:0], 0));
    key_n = 4'hF;
    repeat (PRESS_LAT + 4) tick();
    chk("show_led", state_led, 3'b000);
    m_res   = r[31:0];
    m_state = S_SHOW;
  endtask

  initial begin
    rst = 1'b1; key_n = 4'hF; sw_data = 16'h0; sw_ext = 1'b0;
    m_state = S_A; m_res = 32'h0;
    repeat (3) tick();
    chk("rst_hex", hex, {4{7'h7F}});
    chk("rst_led", state_led, 3'b001);
    chk("rst_flags", flags, 3'b000);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_page", page, 1'b0);
    rst = 1'b0;
    tick(); tick();
    chk("hex_after_rst", hex, exp_hex(S_A, 32'h0, 0));

    // Bouncing commit key never stays stable long enough.
    sw_data = 16'h0005;
    for (int i = 0; i < 20; i++) begin
      key_n[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("bounce_%0d", i), state_led, 3'b001);
    end
    // Stable low: press pulse after PRESS_LAT cycles, FSM moves one cycle later.
    key_n[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("press_edge_%0d", k), state_led, (k > PRESS_LAT) ? 3'b010 : 3'b001);
    end
    key_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("release_%0d", k), state_led, 3'b010);
    end
    chk("bounce_alu_a", alu_a, 32'h5);
    push(4'b0010);
    chk("clear_led", state_led, 3'b001);
    chk("clear_alu_a", alu_a, 32'h0);

    // Directed: 5 + 3, sign extension, and a wide result for paging.
    run_op(16'h0005, 1'b0, 16'h0003, 1'b0, 4'd0);
    chk("full_hex_d0", hex[6:0], 7'b0000000);
    run_op(16'hFFFF, 1'b1, 16'h0001, 1'b0, 4'd0);
    chk("signext_flags", flags, 3'b001);
    run_op(16'h1234, 1'b0, 16'hABCD, 1'b0, 4'd1);
    push(4'b0100);
    chk("page1", page, 1'b1);
    chk("hex_page1", hex, exp_hex(S_SHOW, 32'h1234ABCD, 1));
    push(4'b0100);
    chk("page_wrap", page, 1'b0);
    chk("hex_page0", hex, exp_hex(S_SHOW, 32'h1234ABCD, 0));

    // Randomised operations with an upper-page view of each result.
    for (int n = 0; n < 6; n++) begin
      run_op(16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
             4'($urandom_range(0, 1)));
      push(4'b0100);
      chk("rand_page", page, 1'b1);
      chk("rand_hex_page1", hex, exp_hex(S_SHOW, m_res, 1));
    end

    // Clear beats commit in the same cycle.
    sw_data = 16'h00AA; sw_ext = 1'b0;
    push(4'b0001);
    chk("prio_led_a", state_led, 3'b001);
    chk("prio_page_reset", page, 1'b0);
    push(4'b0001);
    chk("prio_alu_a", alu_a, 32'h000000AA);
    push(4'b0011);
    chk("prio_led", state_led, 3'b001);
    chk("prio_clr_a", alu_a, 32'h0);
    chk("prio_clr_flags", flags, 3'b000);
    m_state = S_A; m_res = 32'h0;

    // Paging during entry, reset by the next state change.
    sw_data = 16'hBEEF; sw_ext = 1'b1;
    push(4'b0100);
    chk("entry_page", page, 1'b1);
    chk("entry_hex_page1", hex, exp_hex(S_A, 32'hFFFFBEEF, 1));
    push(4'b0001);
    chk("entry_page_reset", page, 1'b0);
    push(4'b0010);
    chk("entry_clear_led", state_led, 3'b001);

    // Reset asserted while in EXEC.
    run_op(16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'd0);
    chk("neg_flags", flags, 3'b100);
    push(4'b0001);
    push(4'b0001);
    push(4'b0001);
    chk("pre_exec_led", state_led, 3'b100);
    key_n[0] = 1'b0;
    repeat (PRESS_LAT + 1) tick();
    chk("mid_exec_led", state_led, 3'b000);
    rst = 1'b1;
    #1;
    chk("rst_exec_led", state_led, 3'b001);
    chk("rst_exec_hex", hex, {4{7'h7F}});
    chk("rst_exec_flags", flags, 3'b000);
    chk("rst_exec_alu_a", alu_a, 32'h0);
    key_n = 4'hF;
    tick();
    rst = 1'b0;
    repeat (PRESS_LAT + 4) tick();
    chk("post_rst_led", state_led, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
